fetch_queue: RTL and testbench

//  Instruction fetch stage sitting directly downstream of the instruction ROM. Owns the fetch
//  PC, drives the ROM byte address, captures each 32-bit big-endian-assembled instruction with
//  its PC into a small FIFO, and presents entries to decode over a valid/ready handshake.

---
 rtl/riscv_pkg.sv | 19 +
 rtl/sync_fifo.sv | 62 ++++++
 rtl/fetch_queue.sv | 80 ++++++++
 tb/tb_fetch_queue.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// ============================================================================
// riscv_pkg: shared instruction-fetch types and constants.
// Revision: 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam int          IW        = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// sync_fifo: power-of-two FIFO of fetch entries with synchronous flush.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  fetch_entry_t             wdata,
    output fetch_entry_t             rdata,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; the head is don't-care while empty.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// fetch_queue: fetch PC, ROM addressing and instruction queue towards decode.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_queue
    import riscv_pkg::*;
#(
    parameter int          WAD      = 16,
    parameter int          WD       = 8,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [WAD-1:0]    RomAddr,
    input  logic [4*WD-1:0]   RomData,
    output logic              InstrValid,
    input  logic              InstrReady,
    output logic [4*WD-1:0]   Instr,
    output logic [31:0]       InstrPC,
    input  logic              Redirect,
    input  logic [31:0]       RedirectPC,
    output logic              MisalignErr
);

    logic [31:0]  fetch_pc;
    logic         misalign_err;
    logic         push;
    logic         pop;
    logic         full;
    logic         empty;
    fetch_entry_t wr_entry;
    fetch_entry_t head;

    // Redirect wins over both handshakes; no write-through when full.
    assign push = !full && !Redirect;
    assign pop  = !empty && InstrReady && !Redirect;

    assign wr_entry.instr = RomData;
    assign wr_entry.pc    = fetch_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc     <= RESET_PC;
            misalign_err <= 1'b0;
        end else begin
            if (Redirect) begin
                fetch_pc <= {RedirectPC[31:2], 2'b00};
                if (RedirectPC[1:0] != 2'b00) misalign_err <= 1'b1;
            end else if (push) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (Redirect),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign RomAddr     = fetch_pc[WAD-1:0];
    assign InstrValid  = !empty;
    assign Instr       = head.instr;
    assign InstrPC     = head.pc;
    assign MisalignErr = misalign_err;

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
// tb_fetch_queue: directed vector table plus hand sequences for fetch_queue.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] rom_addr;
    logic [31:0] rom_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        misalign_err;

    logic [15:0] w_rom_addr;
    logic [31:0] w_rom_data;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic        w_redirect;
    logic [31:0] w_redirect_pc;
    logic        w_misalign;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // ROM model: addi x1..x8 at 0..31, a deterministic byte pattern elsewhere
    function automatic logic [31:0] prog_word(input logic [2:0] k);
        case (k)
            3'd0: return 32'h0010_0093;
            3'd1: return 32'h0020_0113;
            3'd2: return 32'h0030_0193;
            3'd3: return 32'h0040_0213;
            3'd4: return 32'h0050_0293;
            3'd5: return 32'h0060_0313;
            3'd6: return 32'h0070_0393;
            default: return 32'h0080_0413;
        endcase
    endfunction

    function automatic logic [7:0] rom_byte(input logic [15:0] a);
        logic [31:0] w;
        if (a < 16'd32) begin
            w = prog_word(a[4:2]);
            case (a[1:0])
                2'd0:    return w[31:24];
                2'd1:    return w[23:16];
                2'd2:    return w[15:8];
                default: return w[7:0];
            endcase
        end
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [31:0] rom_word(input logic [15:0] a);
        logic [15:0] a1, a2, a3;
        a1 = a + 16'd1;
        a2 = a + 16'd2;
        a3 = a + 16'd3;
        return {rom_byte(a), rom_byte(a1), rom_byte(a2), rom_byte(a3)};
    endfunction

    assign rom_data   = rom_word(rom_addr);
    assign w_rom_data = rom_word(w_rom_addr);

    fetch_queue #(
        .WAD(16), .WD(8), .DEPTH(4), .RESET_PC(32'h0000_0000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .RomAddr(rom_addr), .RomData(rom_data),
        .InstrValid(instr_valid), .InstrReady(instr_ready), .Instr(instr),
        .InstrPC(instr_pc), .Redirect(redirect), .RedirectPC(redirect_pc),
        .MisalignErr(misalign_err)
    );

    fetch_queue #(
        .WAD(16), .WD(8), .DEPTH(4), .RESET_PC(32'hFFFF_FFFC)
    ) dut_wrap (
        .clk(clk), .rst_n(rst_n), .RomAddr(w_rom_addr), .RomData(w_rom_data),
        .InstrValid(w_valid), .InstrReady(w_ready), .Instr(w_instr),
        .InstrPC(w_pc), .Redirect(w_redirect), .RedirectPC(w_redirect_pc),
        .MisalignErr(w_misalign)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [15:0] exp_addr;
        logic        exp_mis;
    } vec_t;

    vec_t vecs [17];

    initial begin
        // Streaming from reset: head PC trails the ROM address by one word
        for (int i = 0; i < 10; i++) begin
            vecs[i] = '{1'b1, 1'b0, 32'h0, (i > 0), 32'(4 * (i - 1)), 16'(4 * i), 1'b0};
        end
        vecs[10] = '{1'b1, 1'b1, 32'h40, 1'b1, 32'h24, 16'h28, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  16'h40, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h40, 16'h44, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 32'h22, 1'b1, 32'h44, 16'h48, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  16'h20, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h20, 16'h24, 1'b1};
        vecs[16] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h24, 16'h28, 1'b1};

        rst_n         = 1'b0;
        instr_ready   = 1'b1;
        redirect      = 1'b0;
        redirect_pc   = 32'h0;
        w_ready       = 1'b1;
        w_redirect    = 1'b0;
        w_redirect_pc = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_valid", {31'b0, instr_valid}, 32'd0);
        check("reset_mis", {31'b0, misalign_err}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            check($sformatf("v%0d_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].exp_valid});
            check($sformatf("v%0d_addr", i), {16'b0, rom_addr}, {16'b0, vecs[i].exp_addr});
            check($sformatf("v%0d_mis", i), {31'b0, misalign_err}, {31'b0, vecs[i].exp_mis});
            if (vecs[i].exp_valid) begin
                check($sformatf("v%0d_pc", i), instr_pc, vecs[i].exp_pc);
                check($sformatf("v%0d_instr", i), instr, rom_word(vecs[i].exp_pc[15:0]));
            end
            instr_ready = vecs[i].ready;
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            @(negedge clk);
        end
        redirect = 1'b0;

        // Build up count=3 then assert reset asynchronously mid-cycle
        instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_valid", {31'b0, instr_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'b0, instr_valid}, 32'd0);
        check("async_rst_addr", {16'b0, rom_addr}, 32'd0);
        check("async_rst_mis", {31'b0, misalign_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Backpressure for 10 cycles; wrap instance streams alongside
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin
                check("bp0_valid", {31'b0, instr_valid}, 32'd0);
                check("wrap0_addr", {16'b0, w_rom_addr}, 32'h0000_FFFC);
                check("wrap0_valid", {31'b0, w_valid}, 32'd0);
            end else if (i == 1) begin
                check("bp1_pc", instr_pc, 32'h0);
                check("bp1_instr", instr, 32'h0010_0093);
                check("wrap1_pc", w_pc, 32'hFFFF_FFFC);
                check("wrap1_instr", w_instr, rom_word(16'hFFFC));
                check("wrap1_addr", {16'b0, w_rom_addr}, 32'h0);
            end else if (i == 2) begin
                check("wrap2_pc", w_pc, 32'h0);
                check("wrap2_addr", {16'b0, w_rom_addr}, 32'h4);
            end
            @(negedge clk);
        end
        check("bp_full_addr", {16'b0, rom_addr}, 32'd16);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("drain%0d_valid", k), {31'b0, instr_valid}, 32'd1);
            check($sformatf("drain%0d_pc", k), instr_pc, 32'(4 * k));
            instr_ready = 1'b1;
            @(negedge clk);
        end

        // Redirect with a populated queue: old entries must vanish
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        @(negedge clk);
        redirect = 1'b0;
        check("redir_valid", {31'b0, instr_valid}, 32'd0);
        check("redir_addr", {16'b0, rom_addr}, 32'h40);
        @(negedge clk);
        check("redir_pc", instr_pc, 32'h40);
        check("redir_instr", instr, rom_word(16'h40));
        check("redir_mis", {31'b0, misalign_err}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
